// File: rtl/game_if.sv
// game_if: bundle of game controller player/display signals.
interface game_if;
    logic start;
    logic [3:0] KEY;
    logic player_input;
    logic check;
    logic [17:0] seq;
    logic [5:0] seq_counter;
    logic playerEN;
    logic checkEN;
    logic show_en;
    logic [1:0] show_tile;
    logic [3:0] score;
    logic win;
    logic lose;
    modport master (
        input start, KEY, player_input, check,
        output seq, seq_counter, playerEN, checkEN, show_en, show_tile, score, win, lose
    );
    modport slave (
        output start, KEY, player_input, check,
        input seq, seq_counter, playerEN, checkEN, show_en, show_tile, score, win, lose
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: memory-sequence game controller (playback, input capture, judging).
// Define GAME_TIMEOUT_EN to make WAIT_IN lose after TIMEOUT_TICKS idle cycles.
module game_ctrl #(
    parameter int SHOW_TICKS = 25000000,
    parameter int GAP_TICKS = 12500000,
    parameter int TIMEOUT_TICKS = 250000000
) (
    input logic clk,
    input logic reset,
    game_if.master g
);
    localparam logic [3:0] IDLE = 4'd0, LOAD = 4'd1, SHOW_ON = 4'd2, SHOW_OFF = 4'd3,
                           WAIT_IN = 4'd4, CHECK = 4'd5, JUDGE = 4'd6, RELEASE = 4'd7,
                           WIN = 4'd8, LOSE = 4'd9;
    localparam logic [17:0] SEED = 18'h2A5F3;
    logic [3:0] state, nxt, target, round;
    logic [31:0] tick;
    logic [17:0] lfsr;
    logic [1:0] tile;
    logic last, show_done, gap_done;
    assign last = g.seq_counter == 6'(round) - 6'd1;
    assign show_done = tick == 32'(SHOW_TICKS - 1);
    assign gap_done = tick == 32'(GAP_TICKS - 1);
    // tile k lives in seq[2k+1:2k] with seq[2k] as its MSB
    assign tile = 2'(g.seq >> {g.seq_counter, 1'b0});
    assign g.playerEN = state == WAIT_IN;
    assign g.checkEN = state == CHECK;
    assign g.show_en = state == SHOW_ON;
    assign g.show_tile = (state == SHOW_ON) ? {tile[0], tile[1]} : 2'b00;
    assign g.win = state == WIN;
    assign g.lose = state == LOSE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, WIN, LOSE: nxt = g.start ? LOAD : state;
            LOAD: nxt = SHOW_ON;
            SHOW_ON: nxt = show_done ? SHOW_OFF : state;
            SHOW_OFF: nxt = gap_done ? (last ? WAIT_IN : SHOW_ON) : state;
`ifdef GAME_TIMEOUT_EN
            WAIT_IN: nxt = g.player_input ? CHECK : (tick == 32'(TIMEOUT_TICKS - 1)) ? LOSE : state;
`else
            WAIT_IN: nxt = g.player_input ? CHECK : state;
`endif
            CHECK: nxt = JUDGE;
            JUDGE: nxt = !g.check ? LOSE : (last && round == 4'd9) ? WIN : RELEASE;
            RELEASE: nxt = (g.KEY == 4'hF) ? target : state;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            target <= IDLE;
            tick <= '0;
            lfsr <= SEED;
            round <= '0;
            g.seq <= '0;
            g.seq_counter <= '0;
            g.score <= '0;
        end else begin
            state <= nxt;
            tick <= (nxt != state) ? '0 : tick + 32'd1;
            lfsr <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
            case (state)
                LOAD: begin
                    g.seq <= lfsr;
                    round <= 4'd1;
                    g.score <= '0;
                    g.seq_counter <= '0;
                end
                SHOW_OFF: if (gap_done) g.seq_counter <= last ? '0 : g.seq_counter + 6'd1;
                JUDGE: if (g.check) begin
                    if (!last) begin
                        g.seq_counter <= g.seq_counter + 6'd1;
                        target <= WAIT_IN;
                    end else if (round != 4'd9) begin
                        g.score <= g.score + 4'd1;
                        round <= round + 4'd1;
                        g.seq_counter <= '0;
                        target <= SHOW_ON;
                    end else begin
                        g.score <= 4'd9;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized games against a queue-based reference model of the game rules.
module tb_game_ctrl;
    localparam int SHOW = 4, GAP = 2, TMO = 10;
    localparam int K_SHOW = 0, K_CHK = 1, K_WIN = 2, K_LOSE = 3;
    typedef struct { int kind; logic [17:0] seq; int a; int b; } exp_t;
    logic clk = 0, reset = 1;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q[$];
    game_if g();
    game_ctrl #(.SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (.clk(clk), .reset(reset), .g(g));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // LFSR value n cycles after reset, from the x^18+x^11+1 recurrence
    function automatic logic [17:0] lfsr_at(input int n);
        logic [17:0] v = 18'h2A5F3;
        repeat (n) v = {v[16:0], v[17] ^ v[10]};
        return v;
    endfunction
    function automatic int tile_of(input logic [17:0] s, input int k);
        return int'({s[2*k], s[2*k+1]});
    endfunction
    task automatic push_round(input logic [17:0] s, input int r);
        for (int k = 0; k < r; k++) q.push_back('{K_SHOW, s, tile_of(s, k), k});
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    // ---------------- monitor ----------------
    bit prev_show, prev_chk, prev_end, in_gap, unsteady;
    int on_len, gap_len, chk_len, cur_tile, cur_idx;
    task automatic pop(output exp_t e, output bit ok);
        ok = q.size() != 0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: queue empty at %0t", $time);
        end else e = q.pop_front();
    endtask
    initial forever begin
        exp_t e;
        bit ok;
        @(negedge clk);
        if (reset) begin
            prev_show = 0; prev_chk = 0; prev_end = 0; in_gap = 0;
        end else begin
            if (g.show_en) begin
                if (in_gap) chk("gap_len", gap_len, GAP);
                in_gap = 0;
                if (!prev_show) begin
                    on_len = 0; unsteady = 0; cur_tile = g.show_tile; cur_idx = g.seq_counter;
                end
                unsteady |= int'(g.show_tile) != cur_tile;
                on_len++;
            end else begin
                if (prev_show) begin
                    pop(e, ok);
                    if (ok) begin
                        chk("show_kind", K_SHOW, e.kind);
                        chk("show_tile", cur_tile, e.a);
                        chk("show_idx", cur_idx, e.b);
                        chk("show_len", on_len, SHOW);
                        chk("show_steady", unsteady, 0);
                        chk("seq", g.seq, e.seq);
                    end
                    in_gap = 1; gap_len = 0;
                end
                if (in_gap) begin
                    if (g.playerEN) begin chk("gap_len", gap_len, GAP); in_gap = 0; end
                    else gap_len++;
                end
            end
            if (g.checkEN && !prev_chk) begin
                pop(e, ok);
                if (ok) begin
                    chk("chk_kind", K_CHK, e.kind);
                    chk("chk_score", g.score, e.a);
                    chk("chk_idx", g.seq_counter, e.b);
                    chk("chk_player_en", g.playerEN, 0);
                end
            end
            if (!g.checkEN && prev_chk) chk("chk_len", chk_len, 1);
            chk_len = g.checkEN ? (prev_chk ? chk_len + 1 : 1) : chk_len;
            if ((g.win || g.lose) && !prev_end) begin
                pop(e, ok);
                if (ok) begin
                    chk("end_flags", {g.win, g.lose}, e.kind == K_WIN ? 2 : 1);
                    chk("end_score", g.score, e.a);
                    chk("end_player_en", g.playerEN, 0);
                end
            end
            prev_show = g.show_en; prev_chk = g.checkEN; prev_end = g.win || g.lose;
        end
    end
    // ---------------- driver ----------------
    task automatic check_zero(input string tag);
        chk({tag, "_strobes"}, {g.playerEN, g.checkEN, g.show_en, g.win, g.lose}, 0);
        chk({tag, "_tile"}, g.show_tile, 0);
        chk({tag, "_seq"}, g.seq, 0);
        chk({tag, "_cnt"}, g.seq_counter, 0);
        chk({tag, "_score"}, g.score, 0);
    endtask
    task automatic start_game(output logic [17:0] s, input bit first);
        int n = 1;
        g.start = 1;
        s = lfsr_at(cyc + 1);
        push_round(s, 1);
        step();
        g.start = 0;
        while (!g.show_en && n < 10) begin step(); n++; end
        if (first) chk("start_to_show", n, 2);
        else chk("show_seen", g.show_en, 1);
    endtask
    task automatic wait_player(output bit ok);
        int n = 0;
        while (!g.playerEN && n < 300) begin
            g.player_input = $urandom_range(0, 3) == 0;
            g.start = g.show_en && ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        g.player_input = 0;
        g.start = 0;
        chk("player_wait", g.playerEN, 1);
        ok = g.playerEN;
    endtask
    task automatic wait_end();
        int n = 0;
        while (!(g.win || g.lose) && n < 50) begin step(); n++; end
        chk("end_seen", g.win || g.lose, 1);
    endtask
    task automatic play_game(input int fail_round, input bit first);
        logic [17:0] s;
        bit ok, pass;
        int fail_idx;
        fail_idx = fail_round > 0 ? $urandom_range(0, fail_round - 1) : -1;
        start_game(s, first);
        for (int r = 1; r <= 9; r++) begin
            for (int k = 0; k < r; k++) begin
                wait_player(ok);
                if (!ok) return;
`ifndef GAME_TIMEOUT_EN
                if (first && r == 1) begin
                    repeat (100) step();
                    chk("no_timeout_wait", g.playerEN, 1);
                    chk("no_timeout_lose", g.lose, 0);
                end
`endif
                repeat ($urandom_range(0, 3)) step();
                pass = !(r == fail_round && k == fail_idx);
                g.player_input = 1;
                g.check = pass;
                g.KEY = 4'($urandom_range(0, 14));
                q.push_back('{K_CHK, s, r - 1, k});
                if (!pass) q.push_back('{K_LOSE, s, r - 1, 0});
                else if (k == r - 1) begin
                    if (r == 9) q.push_back('{K_WIN, s, 9, 0});
                    else push_round(s, r + 1);
                end
                step();
                g.player_input = 0;
                repeat ($urandom_range(2, 6)) step();
                g.KEY = 4'hF;
                if (!pass || (r == 9 && k == 8)) begin wait_end(); return; end
            end
        end
    endtask
    initial begin
        logic [17:0] s;
        bit ok;
        g.start = 0; g.player_input = 0; g.check = 0; g.KEY = 4'hF;
        repeat (2) step();
        check_zero("reset");
        reset = 0;
        play_game(0, 1);
        for (int i = 0; i < 4; i++) play_game($urandom_range(1, 9), 0);
        // reset during playback, with start held high
        start_game(s, 0);
        repeat ($urandom_range(0, 2)) step();
        reset = 1; g.start = 1;
        step();
        check_zero("rst_show");
        reset = 0; g.start = 0;
        q.delete();
        // reset during the compare strobe
        start_game(s, 0);
        wait_player(ok);
        g.player_input = 1; g.check = 1; g.KEY = 4'h0;
        q.push_back('{K_CHK, s, 0, 0});
        step();
        g.player_input = 0;
        chk("mid_chk_en", g.checkEN, 1);
        reset = 1;
        step();
        check_zero("rst_chk");
        reset = 0; g.KEY = 4'hF;
        q.delete();
`ifdef GAME_TIMEOUT_EN
        begin
            int n = 0;
            start_game(s, 0);
            wait_player(ok);
            q.push_back('{K_LOSE, s, 0, 0});
            while (g.playerEN && n < 200) begin step(); n++; end
            chk("timeout_cycles", n, TMO);
            chk("timeout_lose", g.lose, 1);
        end
`endif
        play_game($urandom_range(0, 9), 0);
        repeat (5) step();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
